// File: rtl/home_inventory_adc_seq.sv
// ADC capture sequencer: walks channels through a req/ack handshake and packs
// one header word plus one sign-extended sample per channel into the stream FIFO.
module home_inventory_adc_seq #(
    parameter int unsigned NUM_CH_MAX = 8,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned CH_W      = 3,
    localparam int unsigned NCH_W     = 4,
    localparam int unsigned CNT_W     = 16,
    localparam int unsigned DROP_W    = 8,
    localparam int unsigned WORD_W    = 32,
    localparam int unsigned LVL_W     = 17
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              enable_i,
    input  logic              start_i,
    input  logic              snapshot_i,
    input  logic [NCH_W-1:0]  num_ch_i,
    input  logic [CNT_W-1:0]  period_i,
    output logic              adc_req_o,
    output logic [CH_W-1:0]   adc_ch_o,
    input  logic              adc_ack_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic [CNT_W-1:0]  fifo_level_i,
    output logic              fifo_push_o,
    output logic [WORD_W-1:0] fifo_wdata_o,
    output logic              raw_we_o,
    output logic [CH_W-1:0]   raw_idx_o,
    output logic [WORD_W-1:0] raw_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              frame_drop_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_REQ,
        S_GAP,
        S_DONE,
        S_WAIT
    } state_t;

    localparam logic [NCH_W-1:0]  CH_MAX   = NCH_W'(NUM_CH_MAX);
    localparam logic [LVL_W-1:0]  DEPTH    = LVL_W'(FIFO_DEPTH);
    localparam logic [DROP_W-1:0] DROP_SAT = '1;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NCH_W-1:0]    ch_eff_q, ch_eff_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cont_q, cont_d;
    logic                pend_q, pend_d;
    logic                dropped_q, dropped_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;

    logic                adc_req_q, adc_req_d;
    logic [CH_W-1:0]     adc_ch_q, adc_ch_d;
    logic                push_q, push_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                raw_we_q, raw_we_d;
    logic [CH_W-1:0]     raw_idx_q, raw_idx_d;
    logic [WORD_W-1:0]   raw_data_q, raw_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;

    logic [NCH_W-1:0]    ch_eff_c;
    logic [LVL_W-1:0]    need_c;
    logic                space_ok_c;
    logic                trig_c;
    logic                last_ch_c;
    logic [WORD_W-1:0]   sample_c;

    always_comb begin
        ch_eff_c   = (num_ch_i > CH_MAX) ? CH_MAX : num_ch_i;
        need_c     = LVL_W'(fifo_level_i) + LVL_W'(ch_eff_c) + LVL_W'(1);
        space_ok_c = (need_c <= DEPTH);
        trig_c     = snapshot_i | pend_q | (start_i & enable_i);
        last_ch_c  = ({1'b0, ch_q} == (ch_eff_q - NCH_W'(1)));
        sample_c   = WORD_W'($signed(adc_data_i));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        ch_eff_d    = ch_eff_q;
        cnt_d       = cnt_q;
        cont_d      = cont_q;
        pend_d      = pend_q;
        dropped_d   = dropped_q;
        drop_cnt_d  = drop_cnt_q;
        frame_cnt_d = frame_cnt_q;
        push_d      = 1'b0;
        wdata_d     = wdata_q;
        raw_we_d    = 1'b0;
        raw_idx_d   = raw_idx_q;
        raw_data_d  = raw_data_q;
        drop_d      = 1'b0;

        if (snapshot_i && state_q != S_IDLE && state_q != S_WAIT) begin
            pend_d = 1'b1;
        end
        if (start_i && enable_i && state_q != S_IDLE) begin
            cont_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (trig_c) begin
                    pend_d = 1'b0;
                    if (num_ch_i != NCH_W'(0)) begin
                        state_d = S_HDR;
                        if (start_i && enable_i) begin
                            cont_d = 1'b1;
                        end
                    end
                end
            end
            S_HDR: begin
                ch_eff_d  = ch_eff_c;
                ch_d      = '0;
                dropped_d = ~space_ok_c;
                if (space_ok_c) begin
                    push_d  = 1'b1;
                    wdata_d = {4'hA, ch_eff_c, drop_cnt_q, frame_cnt_q};
                    // A zero-channel frame (num_ch changed after the trigger) is header-only
                    state_d = (ch_eff_c == NCH_W'(0)) ? S_DONE : S_REQ;
                end else begin
                    drop_d  = 1'b1;
                    if (drop_cnt_q != DROP_SAT) begin
                        drop_cnt_d = drop_cnt_q + DROP_W'(1);
                    end
                    state_d = S_DONE;
                end
            end
            S_REQ: begin
                if (adc_ack_i) begin
                    push_d     = 1'b1;
                    wdata_d    = sample_c;
                    raw_we_d   = 1'b1;
                    raw_idx_d  = ch_q;
                    raw_data_d = sample_c;
                    if (last_ch_c) begin
                        state_d = S_DONE;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_REQ;
            end
            S_DONE: begin
                if (!dropped_q) begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
                if (pend_q || snapshot_i) begin
                    pend_d  = 1'b0;
                    state_d = S_HDR;
                end else if (cont_d && enable_i && period_i != CNT_W'(0)) begin
                    cnt_d   = period_i - CNT_W'(1);
                    state_d = S_WAIT;
                end else begin
                    cont_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!enable_i) begin
                    cont_d  = 1'b0;
                    state_d = snapshot_i ? S_HDR : S_IDLE;
                end else if (snapshot_i || cnt_q == CNT_W'(0)) begin
                    state_d = S_HDR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        adc_req_d = (state_d == S_REQ);
        adc_ch_d  = ch_d;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            ch_eff_q    <= '0;
            cnt_q       <= '0;
            cont_q      <= 1'b0;
            pend_q      <= 1'b0;
            dropped_q   <= 1'b0;
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
            adc_req_q   <= 1'b0;
            adc_ch_q    <= '0;
            push_q      <= 1'b0;
            wdata_q     <= '0;
            raw_we_q    <= 1'b0;
            raw_idx_q   <= '0;
            raw_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            ch_eff_q    <= ch_eff_d;
            cnt_q       <= cnt_d;
            cont_q      <= cont_d;
            pend_q      <= pend_d;
            dropped_q   <= dropped_d;
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            adc_req_q   <= adc_req_d;
            adc_ch_q    <= adc_ch_d;
            push_q      <= push_d;
            wdata_q     <= wdata_d;
            raw_we_q    <= raw_we_d;
            raw_idx_q   <= raw_idx_d;
            raw_data_q  <= raw_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    assign adc_req_o    = adc_req_q;
    assign adc_ch_o     = adc_ch_q;
    assign fifo_push_o  = push_q;
    assign fifo_wdata_o = wdata_q;
    assign raw_we_o     = raw_we_q;
    assign raw_idx_o    = raw_idx_q;
    assign raw_data_o   = raw_data_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign frame_drop_o = drop_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_home_inventory_adc_seq.sv
// Directed bench for home_inventory_adc_seq: frame packing, continuous mode,
// drop, clamping, pending snapshot and async reset.
module tb_home_inventory_adc_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic        start_i = 1'b0;
    logic        snapshot_i = 1'b0;
    logic [3:0]  num_ch_i = 4'd0;
    logic [15:0] period_i = 16'd0;
    logic        adc_req_o;
    logic [2:0]  adc_ch_o;
    logic        adc_ack_i = 1'b0;
    logic [23:0] adc_data_i = 24'd0;
    logic [15:0] fifo_level_i = 16'd0;
    logic        fifo_push_o;
    logic [31:0] fifo_wdata_o;
    logic        raw_we_o;
    logic [2:0]  raw_idx_o;
    logic [31:0] raw_data_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        frame_drop_o;
    logic [15:0] frame_cnt_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    home_inventory_adc_seq dut (
        .wb_clk_i     (clk),
        .wb_rst_ni    (rst_n),
        .enable_i     (enable_i),
        .start_i      (start_i),
        .snapshot_i   (snapshot_i),
        .num_ch_i     (num_ch_i),
        .period_i     (period_i),
        .adc_req_o    (adc_req_o),
        .adc_ch_o     (adc_ch_o),
        .adc_ack_i    (adc_ack_i),
        .adc_data_i   (adc_data_i),
        .fifo_level_i (fifo_level_i),
        .fifo_push_o  (fifo_push_o),
        .fifo_wdata_o (fifo_wdata_o),
        .raw_we_o     (raw_we_o),
        .raw_idx_o    (raw_idx_o),
        .raw_data_o   (raw_data_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .frame_drop_o (frame_drop_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output log captured on the falling edge
    logic [31:0] pushes[$];
    int          push_cyc[$];
    int          done_cyc[$];
    logic [34:0] raw_log[$];
    int          drop_n = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_push_o) begin
                pushes.push_back(fifo_wdata_o);
                push_cyc.push_back(cyc);
            end
            if (frame_done_o) done_cyc.push_back(cyc);
            if (frame_drop_o) drop_n = drop_n + 1;
            if (raw_we_o) raw_log.push_back({raw_idx_o, raw_data_o});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        pushes.delete();
        push_cyc.delete();
        done_cyc.delete();
        raw_log.delete();
        drop_n = 0;
    endtask

    task automatic pulse_snap();
        snapshot_i = 1'b1;
        tick();
        snapshot_i = 1'b0;
    endtask

    // Wait (bounded) for a request, hold it dly cycles, then ack with d
    task automatic serve(input logic [23:0] d, input int dly, output int waited, output logic [2:0] ch);
        waited = 0;
        while (adc_req_o !== 1'b1 && waited < 200) begin
            tick();
            waited++;
        end
        ch = adc_ch_o;
        if (adc_req_o === 1'b1) begin
            repeat (dly) tick();
            adc_ack_i  = 1'b1;
            adc_data_i = d;
            tick();
            adc_ack_i  = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [111:0] all_o;
        repeat (3) tick();
        all_o = {adc_req_o, adc_ch_o, fifo_push_o, fifo_wdata_o, raw_we_o, raw_idx_o,
                 raw_data_o, busy_o, frame_done_o, frame_drop_o, frame_cnt_o};
        checks++;
        if (all_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_o);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_snapshot();
        int w;
        logic [2:0] ch;
        int trig;
        clear_log();
        num_ch_i = 4'd2;
        trig = cyc;
        pulse_snap();
        serve(24'h800001, 2, w, ch);
        checks++;
        if (w >= 200 || ch !== 3'd0) begin
            errors++;
            $display("FAIL snap_req0: waited %0d ch %0d expected ch 0", w, ch);
        end
        serve(24'h000123, 0, w, ch);
        checks++;
        if (w != 1 || ch !== 3'd1) begin
            errors++;
            $display("FAIL snap_req1: waited %0d ch %0d expected waited 1 ch 1", w, ch);
        end
        repeat (3) tick();
        checks++;
        if (pushes.size() != 3) begin
            errors++;
            $display("FAIL snap_count: got %0d pushes expected 3", pushes.size());
        end else begin
            checks++;
            if (pushes[0] !== 32'hA200_0000 || pushes[1] !== 32'hFF80_0001 || pushes[2] !== 32'h0000_0123) begin
                errors++;
                $display("FAIL snap_words: got %h %h %h expected a2000000 ff800001 00000123",
                         pushes[0], pushes[1], pushes[2]);
            end
            checks++;
            if (push_cyc[0] != trig + 2) begin
                errors++;
                $display("FAIL snap_latency: header at %0d expected %0d", push_cyc[0], trig + 2);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || frame_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL snap_done: done %0d cnt %0d expected 1 1", done_cyc.size(), frame_cnt_o);
        end
        checks++;
        if (raw_log.size() != 2 || raw_log[0] !== {3'd0, 32'hFF80_0001} || raw_log[1] !== {3'd1, 32'h0000_0123}) begin
            errors++;
            $display("FAIL snap_raw: got %0d writes first %h expected 2 writes 0ff800001", raw_log.size(), raw_log[0]);
        end
    endtask

    task automatic test_continuous();
        int w;
        logic [2:0] ch;
        logic [23:0] d;
        clear_log();
        enable_i = 1'b1;
        num_ch_i = 4'd1;
        period_i = 16'd10;
        start_i  = 1'b1;
        tick();
        start_i  = 1'b0;
        for (int f = 0; f < 3; f++) begin
            d = 24'h000100 + 24'(f);
            serve(d, 1, w, ch);
            checks++;
            if (w >= 200 || ch !== 3'd0) begin
                errors++;
                $display("FAIL cont_req%0d: waited %0d ch %0d expected ch 0", f, w, ch);
            end
        end
        repeat (3) tick();
        enable_i = 1'b0;
        repeat (30) tick();
        checks++;
        if (pushes.size() != 6 || done_cyc.size() != 3) begin
            errors++;
            $display("FAIL cont_count: got %0d pushes %0d frames expected 6 3", pushes.size(), done_cyc.size());
        end else begin
            checks++;
            if (pushes[0] !== 32'hA100_0001 || pushes[2] !== 32'hA100_0002 || pushes[4] !== 32'hA100_0003) begin
                errors++;
                $display("FAIL cont_headers: got %h %h %h expected a1000001 a1000002 a1000003",
                         pushes[0], pushes[2], pushes[4]);
            end
            checks++;
            if (pushes[5] !== 32'h0000_0102) begin
                errors++;
                $display("FAIL cont_sample: got %h expected 00000102", pushes[5]);
            end
            checks++;
            if (push_cyc[2] - done_cyc[0] != 12 || push_cyc[4] - done_cyc[1] != 12) begin
                errors++;
                $display("FAIL cont_period: got %0d %0d expected 12 12",
                         push_cyc[2] - done_cyc[0], push_cyc[4] - done_cyc[1]);
            end
        end
        checks++;
        if (busy_o !== 1'b0 || frame_cnt_o !== 16'd4) begin
            errors++;
            $display("FAIL cont_stop: busy %b cnt %0d expected 0 4", busy_o, frame_cnt_o);
        end
        period_i = 16'd0;
    endtask

    task automatic test_drop();
        int w;
        logic [2:0] ch;
        clear_log();
        fifo_level_i = 16'd14;
        num_ch_i = 4'd2;
        pulse_snap();
        repeat (6) tick();
        checks++;
        if (pushes.size() != 0 || drop_n != 1 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL drop_pulse: pushes %0d drops %0d dones %0d expected 0 1 1",
                     pushes.size(), drop_n, done_cyc.size());
        end
        checks++;
        if (frame_cnt_o !== 16'd4) begin
            errors++;
            $display("FAIL drop_cnt_hold: got %0d expected 4", frame_cnt_o);
        end
        clear_log();
        fifo_level_i = 16'd13;
        pulse_snap();
        serve(24'h7FFFFF, 0, w, ch);
        serve(24'h000001, 0, w, ch);
        repeat (3) tick();
        checks++;
        if (pushes.size() != 3 || drop_n != 0) begin
            errors++;
            $display("FAIL drop_boundary: pushes %0d drops %0d expected 3 0", pushes.size(), drop_n);
        end else begin
            checks++;
            if (pushes[0] !== 32'hA201_0004 || pushes[1] !== 32'h007F_FFFF) begin
                errors++;
                $display("FAIL drop_header: got %h %h expected a2010004 007fffff", pushes[0], pushes[1]);
            end
        end
        fifo_level_i = 16'd0;
    endtask

    task automatic test_clamp();
        int w;
        int busy_seen;
        logic [2:0] ch;
        logic [23:0] d;
        clear_log();
        busy_seen = 0;
        num_ch_i = 4'd0;
        pulse_snap();
        for (int i = 0; i < 6; i++) begin
            if (busy_o !== 1'b0) busy_seen++;
            tick();
        end
        checks++;
        if (busy_seen != 0 || pushes.size() != 0 || done_cyc.size() != 0) begin
            errors++;
            $display("FAIL zero_ch: busy %0d pushes %0d dones %0d expected 0 0 0",
                     busy_seen, pushes.size(), done_cyc.size());
        end
        num_ch_i = 4'd12;
        pulse_snap();
        for (int i = 0; i < 8; i++) begin
            d = 24'(i) * 24'h111111;
            serve(d, 0, w, ch);
            if (i == 0) num_ch_i = 4'd3;
            checks++;
            if (ch !== 3'(i)) begin
                errors++;
                $display("FAIL clamp_ch%0d: got %0d expected %0d", i, ch, i);
            end
            if (i > 0) begin
                checks++;
                if (w != 1) begin
                    errors++;
                    $display("FAIL clamp_gap%0d: waited %0d expected 1", i, w);
                end
            end
        end
        repeat (3) tick();
        checks++;
        if (pushes.size() != 9 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL clamp_count: pushes %0d dones %0d expected 9 1", pushes.size(), done_cyc.size());
        end else begin
            checks++;
            if (pushes[0] !== 32'hA801_0005 || pushes[8] !== 32'h0077_7777) begin
                errors++;
                $display("FAIL clamp_words: got %h %h expected a8010005 00777777", pushes[0], pushes[8]);
            end
        end
        checks++;
        if (raw_log.size() != 8 || raw_log[7] !== {3'd7, 32'h0077_7777}) begin
            errors++;
            $display("FAIL clamp_raw: %0d writes last %h expected 8 700777777", raw_log.size(), raw_log[7]);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int n;
        logic [2:0] ch;
        clear_log();
        num_ch_i = 4'd1;
        pulse_snap();
        n = 0;
        while (adc_req_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        pulse_snap();
        tick();
        pulse_snap();
        serve(24'hFFFFFE, 0, w, ch);
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL b2b_req_held: waited %0d expected 0", w);
        end
        serve(24'h000010, 0, w, ch);
        repeat (20) tick();
        checks++;
        if (pushes.size() != 4 || done_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: pushes %0d dones %0d expected 4 2", pushes.size(), done_cyc.size());
        end else begin
            checks++;
            if (pushes[0] !== 32'hA101_0006 || pushes[1] !== 32'hFFFF_FFFE ||
                pushes[2] !== 32'hA101_0007 || pushes[3] !== 32'h0000_0010) begin
                errors++;
                $display("FAIL b2b_words: got %h %h %h %h expected a1010006 fffffffe a1010007 00000010",
                         pushes[0], pushes[1], pushes[2], pushes[3]);
            end
            checks++;
            if (push_cyc[2] - done_cyc[0] != 2) begin
                errors++;
                $display("FAIL b2b_direct: got %0d expected 2", push_cyc[2] - done_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int w;
        int n;
        logic [2:0] ch;
        logic [111:0] all_o;
        clear_log();
        num_ch_i = 4'd2;
        pulse_snap();
        n = 0;
        while (adc_req_o !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (adc_req_o !== 1'b1 || frame_cnt_o !== 16'd8) begin
            errors++;
            $display("FAIL rst_pre: req %b cnt %0d expected 1 8", adc_req_o, frame_cnt_o);
        end
        rst_n = 1'b0;
        #1;
        all_o = {adc_req_o, adc_ch_o, fifo_push_o, fifo_wdata_o, raw_we_o, raw_idx_o,
                 raw_data_o, busy_o, frame_done_o, frame_drop_o, frame_cnt_o};
        checks++;
        if (all_o !== '0) begin
            errors++;
            $display("FAIL rst_async: got %h expected 0", all_o);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clear_log();
        num_ch_i = 4'd1;
        pulse_snap();
        serve(24'h000ABC, 0, w, ch);
        repeat (3) tick();
        checks++;
        if (pushes.size() != 2 || pushes[0] !== 32'hA100_0000 || frame_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL rst_after: pushes %0d header %h cnt %0d expected 2 a1000000 1",
                     pushes.size(), pushes[0], frame_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_continuous();
        test_drop();
        test_clamp();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
